// File: rtl/aesa_radar_clk_pkg.sv
// Shared types and constants for the AESA radar clock-enable generator.
package aesa_radar_clk_pkg;

    localparam int DIV_W_DEF = 16;

    typedef enum logic [1:0] {
        SETTLE = 2'd0,
        LOCKED = 2'd1,
        RECONF = 2'd2
    } state_t;

    typedef struct packed {
        logic [DIV_W_DEF-1:0] div;
        logic [DIV_W_DEF-1:0] phase;
    } ch_cfg_t;

endpackage

// File: rtl/aesa_radar_clk_div_ch.sv
// One strobe channel: shadow/active divide and phase registers plus the phase counter.
module aesa_radar_clk_div_ch
    import aesa_radar_clk_pkg::*;
#(
    parameter int DIV_W     = DIV_W_DEF,
    parameter int DEF_DIV   = 5,
    parameter int DEF_PHASE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic [DIV_W-1:0] wr_div,
    input  logic [DIV_W-1:0] wr_phase,
    input  logic             load,
    input  logic             clear,
    input  logic             run,
    output logic             match
);

    logic [DIV_W-1:0] sh_div;
    logic [DIV_W-1:0] sh_phase;
    logic [DIV_W-1:0] act_div;
    logic [DIV_W-1:0] act_phase;
    logic [DIV_W-1:0] cnt;

    // Shadow registers take validated writes; they never affect strobes directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_div   <= DIV_W'(DEF_DIV);
            sh_phase <= DIV_W'(DEF_PHASE);
        end else if (wr) begin
            sh_div   <= wr_div;
            sh_phase <= wr_phase;
        end
    end

    // Active registers copy the shadow only in the reconfiguration cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_div   <= DIV_W'(DEF_DIV);
            act_phase <= DIV_W'(DEF_PHASE);
        end else if (load) begin
            act_div   <= sh_div;
            act_phase <= sh_phase;
        end
    end

    // Counter runs 0..div-1 while locked and is held at 0 otherwise, keeping channels aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= (cnt == act_div - DIV_W'(1)) ? '0 : cnt + DIV_W'(1);
        end
    end

    assign match = (cnt == act_phase);

endmodule

// File: rtl/aesa_radar_clk_en_gen.sv
// Runtime-reconfigurable multi-channel clock-enable generator with lock indication.
module aesa_radar_clk_en_gen
    import aesa_radar_clk_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int DIV_W       = DIV_W_DEF,
    parameter int LOCK_CYCLES = 64,
    parameter int DEF_DIV     = 5,
    parameter int DEF_PHASE   = 0,
    localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [DIV_W-1:0] cfg_phase,
    input  logic             cfg_commit,
    output logic             cfg_err,
    output logic [N_CH-1:0]  outclk_en,
    output logic             locked
);

    localparam int SC_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES + 1) : 1;
    localparam logic [CH_W:0] N_CH_L = (CH_W + 1)'(N_CH);

    state_t            state;
    state_t            next_state;
    logic [SC_W-1:0]   settle_cnt;
    logic              settle_done;
    logic              accept;
    logic              bad;
    logic              wr_ok;
    logic [N_CH-1:0]   match;

    assign settle_done = (settle_cnt == SC_W'(LOCK_CYCLES - 1));
    // Ready is forced low while reset is held so no write can slip in during reset.
    assign cfg_ready   = ~rst & (state != RECONF);
    assign accept      = cfg_valid & cfg_ready;
    assign bad         = (cfg_div == '0) | (cfg_phase >= cfg_div) | ({1'b0, cfg_ch} >= N_CH_L);
    assign wr_ok       = accept & ~bad;

    // State register.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) state <= SETTLE;
        else     state <= next_state;
    end

    // Next-state: a commit takes priority over completing the settle period.
    always_comb begin
        next_state = state;
        case (state)
            SETTLE: begin
                if (cfg_commit)       next_state = RECONF;
                else if (settle_done) next_state = LOCKED;
            end
            LOCKED: begin
                if (cfg_commit) next_state = RECONF;
            end
            RECONF:  next_state = SETTLE;
            default: next_state = SETTLE;
        endcase
    end

    // Settle counter advances only while remaining in SETTLE; any exit or RECONF clears it.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst)                                          settle_cnt <= '0;
        else if (state == SETTLE && next_state == SETTLE) settle_cnt <= settle_cnt + SC_W'(1);
        else                                              settle_cnt <= '0;
    end

    // Lock flag and write-reject pulse are registered so strobes derive from flops only.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            locked  <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            locked  <= (next_state == LOCKED);
            cfg_err <= accept & bad;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        aesa_radar_clk_div_ch #(
            .DIV_W     (DIV_W),
            .DEF_DIV   (DEF_DIV),
            .DEF_PHASE (DEF_PHASE)
        ) u_ch (
            .clk      (refclk),
            .rst      (rst),
            .wr       (wr_ok && (cfg_ch == CH_W'(i))),
            .wr_div   (cfg_div),
            .wr_phase (cfg_phase),
            .load     (state == RECONF),
            .clear    (state != LOCKED),
            .run      (state == LOCKED),
            .match    (match[i])
        );
    end

    assign outclk_en = {N_CH{locked}} & match;

endmodule
